// File: rtl/ibex_trace_packer_pkg.sv
// Shared types and constants for the Ibex trace packer.
package ibex_trace_pkg;

  localparam int unsigned TS_W   = 28;
  localparam int unsigned DROP_W = 16;

  typedef enum logic [2:0] {
    KIND_IF            = 3'd0,
    KIND_IF_START      = 3'd1,
    KIND_IF_END        = 3'd2,
    KIND_IDEX          = 3'd3,
    KIND_IDEX_MULT_END = 3'd4,
    KIND_OVERFLOW      = 3'd5
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e       kind;
    logic              c;
    logic [TS_W-1:0]   ts;
    logic [31:0]       pc;
    logic [31:0]       data;
  } trace_rec_t;

  localparam int unsigned REC_W = $bits(trace_rec_t);

  // Admission state: passing events through, or owing an overflow marker.
  typedef enum logic {
    ST_PASS = 1'b0,
    ST_PEND = 1'b1
  } adm_state_e;

  // Drop counter add that sticks at all-ones.
  function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] a,
                                                     input logic [1:0]        b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W + 1)'(b);
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/ibex_trace_packer_if.sv
// Event inputs and record output stream of the trace packer.
interface ibex_trace_packer_if;

  logic        if_ev_valid;
  logic [1:0]  if_ev_kind;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        if_c;
  logic [15:0] if_c_insn;
  logic        idex_ev_valid;
  logic        idex_ev_kind;
  logic [31:0] idex_pc;
  logic        out_valid;
  logic [95:0] out_data;
  logic        out_ready;

  modport master (
    output if_ev_valid, if_ev_kind, if_pc, if_insn, if_c, if_c_insn,
    output idex_ev_valid, idex_ev_kind, idex_pc, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  if_ev_valid, if_ev_kind, if_pc, if_insn, if_c, if_c_insn,
    input  idex_ev_valid, idex_ev_kind, idex_pc, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/ibex_trace_fifo_3w1r.sv
// FIFO with up to three ordered writes per cycle and a show-ahead read.
// Writers must never exceed the free space seen at the start of the cycle.
module ibex_trace_fifo_3w1r #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               wr_cnt,
  input  logic [W-1:0]             wr_data [3],
  output logic                     rd_valid,
  output logic [W-1:0]             rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr];
  assign pop      = rd_valid && rd_ready;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) < wr_cnt) mem[wr_ptr + AW'(i)] <= wr_data[i];
      end
      wr_ptr <= wr_ptr + AW'(wr_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      level  <= level + LW'(wr_cnt) - LW'(pop);
    end
  end

endmodule

// File: rtl/ibex_trace_packer.sv
// Timestamps, formats and buffers Ibex IF/IDEX trace events with loss markers.
module ibex_trace_packer
  import ibex_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  ibex_trace_packer_if.slave     bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   lost
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]   ts_q;
  adm_state_e        state_q, state_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              lost_d;
  logic              if_acc, idex_acc;
  logic [1:0]        n;
  logic [LW-1:0]     free;
  trace_rec_t        if_rec, idex_rec, ovf_rec;
  logic              emit_mark, admit;
  logic [1:0]        wr_cnt;
  logic [REC_W-1:0]  wr_data [3];

  assign if_acc   = enable && bus.if_ev_valid && (bus.if_ev_kind != 2'd3);
  assign idex_acc = enable && bus.idex_ev_valid;
  assign n        = {1'b0, if_acc} + {1'b0, idex_acc};
  assign free     = LW'(DEPTH) - fifo_level;

  // Free-running capture timestamp.
  always_ff @(posedge clk) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  // Record formatting for the three possible writes of a cycle.
  always_comb begin
    if_rec      = '0;
    if_rec.kind = trace_kind_e'({1'b0, bus.if_ev_kind});
    if_rec.ts   = ts_q;
    if (bus.if_ev_kind != 2'd1) begin
      if_rec.c    = bus.if_c;
      if_rec.pc   = bus.if_pc;
      if_rec.data = bus.if_c ? {16'h0, bus.if_c_insn} : bus.if_insn;
    end

    idex_rec      = '0;
    idex_rec.kind = bus.idex_ev_kind ? KIND_IDEX_MULT_END : KIND_IDEX;
    idex_rec.ts   = ts_q;
    idex_rec.pc   = bus.idex_pc;

    ovf_rec      = '0;
    ovf_rec.kind = KIND_OVERFLOW;
    ovf_rec.ts   = ts_q;
    ovf_rec.data = {16'h0, drop_q};
  end

  // Admission state, drop counter and sticky loss flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_PASS;
      drop_q  <= '0;
      lost    <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      lost    <= lost_d;
    end
  end

  // All-or-nothing admission; marker, then IF, then IDEX compacted into write slots.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    lost_d     = lost;
    emit_mark  = 1'b0;
    admit      = 1'b0;
    wr_cnt     = '0;
    wr_data[0] = '0;
    wr_data[1] = '0;
    wr_data[2] = '0;

    unique case (state_q)
      ST_PASS: begin
        if (free >= LW'(n)) begin
          admit = 1'b1;
        end else begin
          state_d = ST_PEND;
          drop_d  = DROP_W'(n);
          lost_d  = 1'b1;
        end
      end
      ST_PEND: begin
        if (free >= LW'(n) + LW'(1)) begin
          emit_mark = 1'b1;
          admit     = 1'b1;
          state_d   = ST_PASS;
          drop_d    = '0;
        end else begin
          drop_d = drop_sat_add(drop_q, n);
        end
      end
    endcase

    if (emit_mark) begin
      wr_data[wr_cnt] = ovf_rec;
      wr_cnt          = wr_cnt + 2'd1;
    end
    if (admit && if_acc) begin
      wr_data[wr_cnt] = if_rec;
      wr_cnt          = wr_cnt + 2'd1;
    end
    if (admit && idex_acc) begin
      wr_data[wr_cnt] = idex_rec;
      wr_cnt          = wr_cnt + 2'd1;
    end
  end

  ibex_trace_fifo_3w1r #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_cnt   (wr_cnt),
    .wr_data  (wr_data),
    .rd_valid (bus.out_valid),
    .rd_data  (bus.out_data),
    .rd_ready (bus.out_ready),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_ibex_trace_packer.sv
// Directed bench for ibex_trace_packer (DEPTH = 16).
module tb_ibex_trace_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [4:0]  fifo_level;
  logic        lost;

  int          tests = 0;
  int          fails = 0;
  logic [27:0] now;

  ibex_trace_packer_if bus ();

  ibex_trace_packer #(.DEPTH(16), .TS_W(28)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bus        (bus),
    .fifo_level (fifo_level),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] mk(input logic [2:0] k, input logic c, input logic [27:0] ts,
                                     input logic [31:0] pc, input logic [31:0] d);
    return {k, c, ts, pc, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    now = now + 28'd1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.if_ev_valid   = 1'b0;
    bus.idex_ev_valid = 1'b0;
  endtask

  task automatic drive_if(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] insn,
                          input logic c, input logic [15:0] cinsn);
    bus.if_ev_valid = 1'b1;
    bus.if_ev_kind  = k;
    bus.if_pc       = pc;
    bus.if_insn     = insn;
    bus.if_c        = c;
    bus.if_c_insn   = cinsn;
  endtask

  task automatic drive_idex(input logic k, input logic [31:0] pc);
    bus.idex_ev_valid = 1'b1;
    bus.idex_ev_kind  = k;
    bus.idex_pc       = pc;
  endtask

  initial begin
    logic [95:0] expq [$];
    logic [95:0] prev_d;
    logic [95:0] d;
    logic        v, r, prev_stall;
    logic [27:0] s;
    int          issued, cyc;

    rst_n = 1'b0;
    enable = 1'b1;
    now = '0;
    idle();
    bus.if_ev_kind = '0; bus.if_pc = '0; bus.if_insn = '0; bus.if_c = 1'b0; bus.if_c_insn = '0;
    bus.idex_ev_kind = 1'b0; bus.idex_pc = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();

    chk("reset_valid", 96'(bus.out_valid), 96'(0));
    chk("reset_data",  bus.out_data, 96'(0));
    chk("reset_level", 96'(fifo_level), 96'(0));
    chk("reset_lost",  96'(lost), 96'(0));

    // Single IF captured at ts = 5
    rst_n = 1'b1;
    now = '0;
    repeat (5) tick();
    drive_if(2'd0, 32'h100, 32'h0000_0013, 1'b0, 16'h0);
    tick();
    idle();
    chk("single_if_valid", 96'(bus.out_valid), 96'(1));
    chk("single_if_data",  bus.out_data, mk(3'd0, 1'b0, 28'd5, 32'h100, 32'h13));
    chk("single_if_level", 96'(fifo_level), 96'(1));
    bus.out_ready = 1'b1;
    tick();
    chk("single_if_drained", 96'(fifo_level), 96'(0));
    chk("single_if_empty", 96'(bus.out_valid), 96'(0));

    // Disabled capture and illegal IF kind are both ignored
    bus.out_ready = 1'b0;
    enable = 1'b0;
    drive_if(2'd0, 32'h104, 32'h1, 1'b0, 16'h0);
    drive_idex(1'b0, 32'h108);
    tick();
    enable = 1'b1;
    drive_if(2'd3, 32'h10C, 32'h2, 1'b0, 16'h0);
    idle();
    bus.if_ev_valid = 1'b1;
    tick();
    idle();
    chk("ignored_level", 96'(fifo_level), 96'(0));

    // Same-cycle IF_END (compressed) and IDEX_MULT_END
    s = now;
    drive_if(2'd2, 32'h0FA, 32'h0000_4501, 1'b1, 16'h4501);
    drive_idex(1'b1, 32'h0FC);
    tick();
    idle();
    chk("dual_level", 96'(fifo_level), 96'(2));
    chk("dual_first", bus.out_data, mk(3'd2, 1'b1, s, 32'h0FA, 32'h4501));
    bus.out_ready = 1'b1;
    tick();
    chk("dual_second", bus.out_data, mk(3'd4, 1'b0, s, 32'h0FC, 32'h0));
    tick();
    chk("dual_drained", 96'(fifo_level), 96'(0));

    // IF_START record zeroes pc and data
    s = now;
    drive_if(2'd1, 32'h200, 32'hDEAD_BEEF, 1'b1, 16'hBEEF);
    tick();
    idle();
    chk("if_start", bus.out_data, mk(3'd1, 1'b0, s, 32'h0, 32'h0));
    tick();

    // Backpressure: random ready, level-gated issue, order and stall stability
    issued = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    while (!(issued == 100 && expq.size() == 0) && cyc < 3000) begin
      v = bus.out_valid;
      d = bus.out_data;
      if (prev_stall) chk("bp_stable", d, prev_d);
      r = ($urandom_range(0, 3) != 0);
      bus.out_ready = r;
      if (v && r) begin
        if (expq.size() == 0) chk("bp_unexpected", d, 96'(0) - 96'(1));
        else chk("bp_order", d, expq.pop_front());
      end
      if (issued < 100 && fifo_level < 5'd12 && $urandom_range(0, 1) == 1) begin
        drive_if(2'd0, 32'h1000 + 32'(issued) * 4, 32'(issued), 1'b0, 16'h0);
        expq.push_back(mk(3'd0, 1'b0, now, 32'h1000 + 32'(issued) * 4, 32'(issued)));
        issued++;
      end else begin
        idle();
      end
      prev_stall = v && !r;
      prev_d = d;
      tick();
      cyc++;
    end
    idle();
    chk("bp_completed", 96'(cyc < 3000), 96'(1));
    chk("bp_no_loss", 96'(lost), 96'(0));
    expq.delete();
    bus.out_ready = 1'b1;
    tick();
    chk("bp_level_end", 96'(fifo_level), 96'(0));

    // Overflow: 8 dual cycles fill, 9th dropped, marker emitted later
    bus.out_ready = 1'b0;
    s = now;
    for (int k = 0; k < 9; k++) begin
      drive_if(2'd0, 32'h200 + 32'(k) * 8, 32'(k), 1'b0, 16'h0);
      drive_idex(1'b0, 32'h204 + 32'(k) * 8);
      tick();
      if (k == 7) begin
        chk("ovf_full_level", 96'(fifo_level), 96'(16));
        chk("ovf_full_lost", 96'(lost), 96'(0));
      end
    end
    idle();
    chk("ovf_drop_level", 96'(fifo_level), 96'(16));
    chk("ovf_drop_lost", 96'(lost), 96'(1));
    chk("ovf_head_stable", bus.out_data, mk(3'd0, 1'b0, s, 32'h200, 32'h0));
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("ovf_after_marker_level", 96'(fifo_level), 96'(14));
    bus.out_ready = 1'b0;
    drive_idex(1'b0, 32'h300);
    tick();
    idle();
    chk("ovf_post_level", 96'(fifo_level), 96'(15));
    expq.push_back(mk(3'd3, 1'b0, s + 28'd1, 32'h20C, 32'h0));
    for (int k = 2; k < 8; k++) begin
      expq.push_back(mk(3'd0, 1'b0, s + 28'(k), 32'h200 + 32'(k) * 8, 32'(k)));
      expq.push_back(mk(3'd3, 1'b0, s + 28'(k), 32'h204 + 32'(k) * 8, 32'h0));
    end
    expq.push_back(mk(3'd5, 1'b0, s + 28'd10, 32'h0, 32'h2));
    expq.push_back(mk(3'd3, 1'b0, s + 28'd12, 32'h300, 32'h0));
    bus.out_ready = 1'b1;
    while (expq.size() != 0) begin
      chk("ovf_drain", bus.out_data, expq.pop_front());
      tick();
    end
    chk("ovf_drain_level", 96'(fifo_level), 96'(0));
    chk("ovf_lost_sticky", 96'(lost), 96'(1));

    // Timestamp wrap
    force dut.ts_q = 28'hFFF_FFFE;
    #1;
    release dut.ts_q;
    tick();
    drive_if(2'd0, 32'h400, 32'h40, 1'b0, 16'h0);
    tick();
    chk("wrap_max", bus.out_data, mk(3'd0, 1'b0, 28'hFFF_FFFF, 32'h400, 32'h40));
    drive_if(2'd0, 32'h404, 32'h41, 1'b0, 16'h0);
    tick();
    chk("wrap_zero", bus.out_data, mk(3'd0, 1'b0, 28'd0, 32'h404, 32'h41));
    drive_if(2'd0, 32'h408, 32'h42, 1'b0, 16'h0);
    tick();
    idle();
    chk("wrap_one", bus.out_data, mk(3'd0, 1'b0, 28'd1, 32'h408, 32'h42));
    tick();

    // Reset mid-stream with seven records buffered
    bus.out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive_if(2'd0, 32'h500 + 32'(k) * 4, 32'(k), 1'b0, 16'h0);
      tick();
    end
    idle();
    chk("mid_level7", 96'(fifo_level), 96'(7));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 96'(bus.out_valid), 96'(0));
    chk("mid_rst_level", 96'(fifo_level), 96'(0));
    chk("mid_rst_lost", 96'(lost), 96'(0));
    chk("mid_rst_data", bus.out_data, 96'(0));
    rst_n = 1'b1;
    drive_if(2'd0, 32'h600, 32'h77, 1'b0, 16'h0);
    tick();
    idle();
    chk("mid_rst_ts0", bus.out_data, mk(3'd0, 1'b0, 28'd0, 32'h600, 32'h77));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
